regbank_mp: RTL and testbench

- Parametrised successor of the processor's 8x16 register bank.
- Provides two combinational read ports, one synchronous write port, and a dedicated program-counter register with auto-increment.
- Adds a per-register busy scoreboard so the control FSM can detect read-after-write hazards on multi-cycle instructions.
- Sits between the instruction decoder/control unit and the ALU/bus mux of the datapath.

---
 rtl/regbank_pkg.sv | 23 ++
 rtl/regbank_mp_if.sv | 37 +++
 rtl/regbank_scoreboard.sv | 37 +++
 rtl/regbank_mp.sv | 82 ++++++++
 tb/tb_regbank_mp.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared constants and helpers for the multi-port register bank
package regbank_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;
  localparam int PC_STEP_DEF  = 1;

  // Number of bits needed to index 'value' entries (value >= 2).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  localparam int IDX_W = clog2(NUM_REGS_DEF);

endpackage

// File: rtl/regbank_mp_if.sv
// rtl/regbank_mp_if.sv - decoder/control side bus of the register bank
interface regbank_mp_if
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = clog2(NUM_REGS)
);

  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [SEL_W-1:0]  rd_sel_a;
  logic [SEL_W-1:0]  rd_sel_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              incr_pc;
  logic              mark_en;
  logic [SEL_W-1:0]  mark_sel;
  logic [DATA_W-1:0] pc_data;
  logic [NUM_REGS-1:0] busy_vec;

  // Control unit side: issues writes, marks, increments and read selects.
  modport master (
    output wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b, incr_pc, mark_en, mark_sel,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, pc_data, busy_vec
  );

  // Register bank side.
  modport slave (
    input  wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b, incr_pc, mark_en, mark_sel,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, pc_data, busy_vec
  );

endinterface

// File: rtl/regbank_scoreboard.sv
// rtl/regbank_scoreboard.sv - per-register busy bits with mark-over-write priority
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic                mark_en,
  input  logic [SEL_W-1:0]    mark_sel,
  input  logic [SEL_W-1:0]    rd_sel_a,
  input  logic [SEL_W-1:0]    rd_sel_b,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                busy_a,
  output logic                busy_b
);

  logic [NUM_REGS-1:0] busy;

  // A write retires its register; a mark issued in the same cycle is applied last so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_en)   busy[wr_sel]   <= 1'b0;
      if (mark_en) busy[mark_sel] <= 1'b1;
    end
  end

  assign busy_vec = busy;
  assign busy_a   = busy[rd_sel_a];
  assign busy_b   = busy[rd_sel_b];

endmodule

// File: rtl/regbank_mp.sv
// rtl/regbank_mp.sv - register bank with PC auto-increment and busy scoreboard; REGBANK_BYPASS_EN adds write-to-read forwarding
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int PC_IDX   = NUM_REGS - 1,
  parameter int PC_STEP  = PC_STEP_DEF
) (
  input logic        clk,
  input logic        reset_n,
  regbank_mp_if.slave bus
);

  localparam int SEL_W = clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              sb_busy_a;
  logic              sb_busy_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] pc_val;
  logic              busy_a;
  logic              busy_b;

  // Data array: the increment is issued first so a same-cycle PC write overrides it.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (bus.incr_pc) regs[PC_IDX] <= regs[PC_IDX] + DATA_W'(PC_STEP);
      if (bus.wr_en)   regs[bus.wr_sel] <= bus.wr_data;
    end
  end

  regbank_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (reset_n),
    .wr_en    (bus.wr_en),
    .wr_sel   (bus.wr_sel),
    .mark_en  (bus.mark_en),
    .mark_sel (bus.mark_sel),
    .rd_sel_a (bus.rd_sel_a),
    .rd_sel_b (bus.rd_sel_b),
    .busy_vec (bus.busy_vec),
    .busy_a   (sb_busy_a),
    .busy_b   (sb_busy_b)
  );

  // Read ports: stored state, optionally overridden by the write in flight this cycle.
  always_comb begin
    data_a = regs[bus.rd_sel_a];
    data_b = regs[bus.rd_sel_b];
    pc_val = regs[PC_IDX];
    busy_a = sb_busy_a;
    busy_b = sb_busy_b;
`ifdef REGBANK_BYPASS_EN
    // Forwarded data is final; its busy bit shows the post-edge value (a same-index mark keeps it set).
    if (bus.wr_en && (bus.wr_sel == bus.rd_sel_a)) begin
      data_a = bus.wr_data;
      busy_a = bus.mark_en && (bus.mark_sel == bus.rd_sel_a);
    end
    if (bus.wr_en && (bus.wr_sel == bus.rd_sel_b)) begin
      data_b = bus.wr_data;
      busy_b = bus.mark_en && (bus.mark_sel == bus.rd_sel_b);
    end
    if (bus.wr_en && (bus.wr_sel == SEL_W'(PC_IDX))) begin
      pc_val = bus.wr_data;
    end
`endif
  end

  assign bus.rd_data_a = data_a;
  assign bus.rd_data_b = data_b;
  assign bus.rd_busy_a = busy_a;
  assign bus.rd_busy_b = busy_b;
  assign bus.pc_data   = pc_val;

endmodule

// File: tb/tb_regbank_mp.sv
// tb/tb_regbank_mp.sv - directed self-checking bench for regbank_mp
module tb_regbank_mp;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  regbank_mp_if #(.DATA_W(16), .NUM_REGS(8)) bus ();

  regbank_mp dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.incr_pc = 1'b0;
    bus.mark_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n      = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_sel   = '0;
    bus.wr_data  = '0;
    bus.rd_sel_a = '0;
    bus.rd_sel_b = '0;
    bus.incr_pc  = 1'b0;
    bus.mark_en  = 1'b0;
    bus.mark_sel = '0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("reset_pc", bus.pc_data, 32'h0);
    chk("reset_busy_vec", bus.busy_vec, 32'h0);
    chk("reset_rd_a", bus.rd_data_a, 32'h0);
    chk("reset_busy_a", bus.rd_busy_a, 32'h0);

    // Write R3 and mark it, then reset asynchronously in mid-cycle.
    tick();
    bus.wr_en = 1'b1; bus.wr_sel = 3'd3; bus.wr_data = 16'h1234;
    bus.mark_en = 1'b1; bus.mark_sel = 3'd3;
    tick();
    idle();
    bus.rd_sel_a = 3'd3;
    #1;
    chk("pre_reset_r3", bus.rd_data_a, 32'h1234);
    chk("pre_reset_busy", bus.busy_vec, 32'h08);
    #1;
    reset_n = 1'b1;
    #1;
    chk("async_reset_r3", bus.rd_data_a, 32'h0);
    chk("async_reset_busy", bus.busy_vec, 32'h0);
    reset_n = 1'b0;

    // Dual read.
    tick();
    bus.wr_en = 1'b1; bus.wr_sel = 3'd1; bus.wr_data = 16'h00AA;
    tick();
    bus.wr_sel = 3'd2; bus.wr_data = 16'h0055;
    tick();
    idle();
    bus.rd_sel_a = 3'd1; bus.rd_sel_b = 3'd2;
    #1;
    chk("dual_a", bus.rd_data_a, 32'h00AA);
    chk("dual_b", bus.rd_data_b, 32'h0055);
    bus.rd_sel_b = 3'd1;
    #1;
    chk("same_a", bus.rd_data_a, 32'h00AA);
    chk("same_b", bus.rd_data_b, 32'h00AA);

    // PC wrap.
    bus.wr_en = 1'b1; bus.wr_sel = 3'd7; bus.wr_data = 16'hFFFE;
    tick();
    idle();
    chk("pc_load", bus.pc_data, 32'hFFFE);
    bus.incr_pc = 1'b1;
    tick();
    chk("pc_inc1", bus.pc_data, 32'hFFFF);
    tick();
    chk("pc_wrap", bus.pc_data, 32'h0000);
    tick();
    chk("pc_inc3", bus.pc_data, 32'h0001);

    // PC write/increment collision: write wins.
    bus.wr_en = 1'b1; bus.wr_sel = 3'd7; bus.wr_data = 16'h0100;
    tick();
    chk("pc_collision", bus.pc_data, 32'h0100);

    // Increment with a write to another register: both apply.
    bus.wr_sel = 3'd0; bus.wr_data = 16'h0777;
    tick();
    idle();
    bus.rd_sel_a = 3'd0;
    #1;
    chk("pc_inc_parallel", bus.pc_data, 32'h0101);
    chk("r0_parallel", bus.rd_data_a, 32'h0777);

    // Scoreboard.
    bus.mark_en = 1'b1; bus.mark_sel = 3'd4;
    tick();
    idle();
    bus.rd_sel_a = 3'd4;
    #1;
    chk("sb_mark_busy_a", bus.rd_busy_a, 32'h1);
    chk("sb_mark_vec", bus.busy_vec, 32'h10);
    bus.wr_en = 1'b1; bus.wr_sel = 3'd4; bus.wr_data = 16'h0042;
    tick();
    idle();
    chk("sb_clear_vec", bus.busy_vec, 32'h00);
    chk("sb_clear_busy_a", bus.rd_busy_a, 32'h0);
    chk("sb_r4_data", bus.rd_data_a, 32'h0042);
    bus.wr_en = 1'b1; bus.wr_sel = 3'd5; bus.wr_data = 16'h0005;
    bus.mark_en = 1'b1; bus.mark_sel = 3'd5;
    tick();
    chk("sb_mark_wins", bus.busy_vec, 32'h20);
    bus.wr_sel = 3'd0; bus.wr_data = 16'h0999;
    bus.mark_sel = 3'd6;
    tick();
    idle();
    bus.rd_sel_a = 3'd0;
    #1;
    chk("sb_mark_diff", bus.busy_vec, 32'h60);
    chk("sb_write_diff", bus.rd_data_a, 32'h0999);

    // Bypass: R6 holds 0 and is busy.
    bus.rd_sel_b = 3'd6;
    bus.wr_en = 1'b1; bus.wr_sel = 3'd6; bus.wr_data = 16'hBEEF;
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("bypass_data_b", bus.rd_data_b, 32'hBEEF);
    chk("bypass_busy_b", bus.rd_busy_b, 32'h0);
`else
    chk("nobypass_data_b", bus.rd_data_b, 32'h0000);
    chk("nobypass_busy_b", bus.rd_busy_b, 32'h1);
`endif
    tick();
    idle();
    #1;
    chk("after_write_data_b", bus.rd_data_b, 32'hBEEF);
    chk("after_write_busy_b", bus.rd_busy_b, 32'h0);
    chk("final_busy_vec", bus.busy_vec, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
